lx_bus_arbiter: RTL and testbench
=================================

# lx_bus_arbiter

Arbitrates ownership of the shared coherence bus between the NUM_PORTS lower-level cache bus interfaces and the single Lx bus interface. The Lx side requests the bus through its `pending_requests` output when it must drive REQ_FLUSH or other outgoing messages. The block issues one-hot, registered grants. L1 ports are served round-robin, and the Lx port has bounded priority. One bus-turnaround cycle is inserted between owners. A hold watchdog flags a grant that is never released.

## Interface
Parameters:
- NUM_PORTS, 4: number of L1-side requesters; must be ≥ 2 and a power of two.
- MAX_HOLD, 64: grant length in cycles at which `hold_timeout` sets.
- HOLD_BITS, 8: width of the hold counter; must satisfy 2^HOLD_BITS > MAX_HOLD.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- requests  input  NUM_PORTS  per-L1-port bus request; held high for the whole transaction.
- lx_request  input  1  Lx bus interface `pending_requests`.
- grant  output  NUM_PORTS  one-hot L1 grant; registered.
- lx_grant  output  1  Lx grant; registered.
- grant_id  output  log2(NUM_PORTS)  index of the granted L1 port; 0 when no L1 grant.
- bus_busy  output  1  high while in GRANT.
- hold_timeout  output  1  sticky flag set when a grant reaches MAX_HOLD cycles.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one owner.
  - RELEASE: one turnaround cycle, no owner.
- IDLE or RELEASE with no request pending (`requests`==0 and `lx_request`==0): go to IDLE.
- IDLE or RELEASE with a request pending: go to GRANT and register the winner.
- Winner selection:
  - If `lx_request` is high and `lx_skip`==0: Lx wins.
  - Otherwise the first set bit of `requests` wins, searching upward from `rr_ptr`+1 modulo NUM_PORTS.
  - If `lx_request` is high, `lx_skip`==1 and `requests`==0: Lx wins anyway.
- `lx_skip`:
  - Set when Lx is granted.
  - Cleared when any L1 port is granted.
  - Effect: Lx never wins two consecutive arbitrations while an L1 request is pending.
- `rr_ptr` updates to the winner index only on an L1 grant. An Lx grant leaves it unchanged.
- GRANT holds the owner while its request bit (or `lx_request`) stays high. Requests from other ports are ignored while in GRANT.
- When the owner's request goes low at an edge, the next state is RELEASE and all grants go low.
- Hold counter:
  - Cleared on entry to GRANT; increments each GRANT cycle and saturates at all ones.
  - When the count equals MAX_HOLD, `hold_timeout` sets. It stays set until reset.
  - The grant is not revoked when `hold_timeout` sets.
- Output reset values, all asynchronous:
  - `grant`=0, `lx_grant`=0, `grant_id`=0, `bus_busy`=0, `hold_timeout`=0.
- Internal reset values, all asynchronous:
  - state=IDLE, `rr_ptr`=NUM_PORTS-1 so port 0 wins first, `lx_skip`=0, hold counter=0.

## Timing
- Grant latency: a request that is high at edge k in IDLE or RELEASE produces a grant visible after edge k (1 cycle).
- Release: owner request low at edge k → grants low after edge k. The cycle after edge k is RELEASE. The next grant is visible after edge k+1 at the earliest.
- Minimum gap between owners: exactly one cycle with all grants low.
- At most one bit of {`grant`, `lx_grant`} is set in any cycle.
- Simultaneous owner release and new request at the same edge: the edge goes to RELEASE. The new request is arbitrated at the following edge.
- A request that is dropped before it is granted is forgotten. No request state is latched.
- Reset asserted during GRANT: grants drop immediately, without waiting for a clock edge. After reset deasserts, the first arbitration starts from port 0.
- `bus_busy` equals the OR of all grants. `grant_id` is valid whenever `grant` is nonzero.

## Test plan
NUM_PORTS=4, MAX_HOLD=8.
1. Reset then idle: hold reset low for 3 cycles with `requests`=4'b1111 → all outputs 0 during reset. Release reset → `grant`=4'b0001 one cycle later, `grant_id`=0.
2. Round-robin: `requests`=4'b1111; each owner holds for 3 cycles and then drops for exactly 1 cycle.
   - Required grant order: 0,1,2,3,0.
   - Exactly one all-zero cycle between consecutive grants.
3. Lx priority and anti-starvation: `lx_request`=1 and `requests`=4'b0100 at the same edge from IDLE.
   - `lx_grant` first. Lx releases and re-requests at once → port 2 is granted next.
   - Lx with `requests`=0 → two consecutive Lx grants allowed.
4. Sparse wrap: `rr_ptr`=3 and `requests`=4'b0110 → port 1 granted, then port 2. Port 0 requests mid-grant → port 0 is served after port 2, not before.
5. Watchdog: port 1 holds its request for 12 cycles.
   - `hold_timeout` rises after the 8th GRANT cycle and the grant stays high.
   - `hold_timeout` remains set after release and clears only on reset.
6. Reset mid-grant: assert reset between edges while `lx_grant`=1 → `lx_grant` falls without waiting for an edge. After deassert with `requests`=4'b1000 → `grant`=4'b1000 one cycle later.

Source files
------------

// File: rtl/lx_bus_arbiter.sv
// Coherence bus arbiter: one-hot registered grants for NUM_PORTS L1 requesters
// plus the Lx interface, with round-robin L1 service, bounded Lx priority and a hold watchdog.
module lx_bus_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned MAX_HOLD  = 64,
    parameter int unsigned HOLD_BITS = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         requests,
    input  logic                         lx_request,
    output logic [NUM_PORTS-1:0]         grant,
    output logic                         lx_grant,
    output logic [$clog2(NUM_PORTS)-1:0] grant_id,
    output logic                         bus_busy,
    output logic                         hold_timeout
);

    localparam int unsigned ID_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                   lx_skip_q, lx_skip_d;
    logic [HOLD_BITS-1:0]   hold_cnt_q, hold_cnt_d;

    logic [NUM_PORTS-1:0]   grant_d;
    logic                   lx_grant_d;
    logic [ID_W-1:0]        grant_id_d;
    logic                   bus_busy_d;
    logic                   hold_timeout_d;

    logic                   l1_found;
    logic [ID_W-1:0]        l1_win;
    logic [ID_W-1:0]        cand;
    logic                   lx_wins;
    logic                   owner_held;

    // Round-robin search starting just above the last L1 winner; the index wraps
    // naturally because NUM_PORTS is a power of two.
    always_comb begin
        l1_found = 1'b0;
        l1_win   = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = rr_ptr_q + ID_W'(i);
            if (!l1_found && requests[cand]) begin
                l1_found = 1'b1;
                l1_win   = cand;
            end
        end
        // Lx yields once after its own grant, unless no L1 port is asking.
        lx_wins = lx_request && (!lx_skip_q || !l1_found);
    end

    assign owner_held = lx_grant ? lx_request : requests[grant_id];

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        lx_skip_d      = lx_skip_q;
        hold_cnt_d     = hold_cnt_q;
        grant_d        = grant;
        lx_grant_d     = lx_grant;
        grant_id_d     = grant_id;
        bus_busy_d     = bus_busy;
        hold_timeout_d = hold_timeout;

        case (state_q)
            IDLE, RELEASE: begin
                grant_d    = '0;
                lx_grant_d = 1'b0;
                grant_id_d = '0;
                bus_busy_d = 1'b0;
                if (lx_wins) begin
                    state_d    = GRANT;
                    lx_grant_d = 1'b1;
                    bus_busy_d = 1'b1;
                    lx_skip_d  = 1'b1;
                    hold_cnt_d = '0;
                end else if (l1_found) begin
                    state_d          = GRANT;
                    grant_d[l1_win]  = 1'b1;
                    grant_id_d       = l1_win;
                    bus_busy_d       = 1'b1;
                    lx_skip_d        = 1'b0;
                    rr_ptr_d         = l1_win;
                    hold_cnt_d       = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HOLD_BITS'(1);
                if (hold_cnt_d == HOLD_BITS'(MAX_HOLD)) begin
                    hold_timeout_d = 1'b1;
                end
                if (!owner_held) begin
                    state_d    = RELEASE;
                    grant_d    = '0;
                    lx_grant_d = 1'b0;
                    grant_id_d = '0;
                    bus_busy_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                lx_grant_d = 1'b0;
                grant_id_d = '0;
                bus_busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears grants immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= ID_W'(NUM_PORTS - 1);
            lx_skip_q    <= 1'b0;
            hold_cnt_q   <= '0;
            grant        <= '0;
            lx_grant     <= 1'b0;
            grant_id     <= '0;
            bus_busy     <= 1'b0;
            hold_timeout <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lx_skip_q    <= lx_skip_d;
            hold_cnt_q   <= hold_cnt_d;
            grant        <= grant_d;
            lx_grant     <= lx_grant_d;
            grant_id     <= grant_id_d;
            bus_busy     <= bus_busy_d;
            hold_timeout <= hold_timeout_d;
        end
    end

endmodule

// File: tb/tb_lx_bus_arbiter.sv
// Bench for lx_bus_arbiter: directed scenarios plus random traffic, checked each cycle
// against a bus-ownership reference model.
module tb_lx_bus_arbiter;

    localparam int NP = 4;
    localparam int MH = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NP-1:0] requests = '0;
    logic          lx_request = 1'b0;
    logic [NP-1:0] grant;
    logic          lx_grant;
    logic [1:0]    grant_id;
    logic          bus_busy;
    logic          hold_timeout;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: owner -1 = nobody, 0..NP-1 = L1 port, NP = Lx.
    int m_owner = -1;
    int m_last  = NP - 1;
    int m_hold  = 0;
    bit m_skip  = 1'b0;
    bit m_to    = 1'b0;

    lx_bus_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(MH), .HOLD_BITS(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .requests    (requests),
        .lx_request  (lx_request),
        .grant       (grant),
        .lx_grant    (lx_grant),
        .grant_id    (grant_id),
        .bus_busy    (bus_busy),
        .hold_timeout(hold_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int pick;
        int p;
        pick = -1;
        if (!reset) begin
            m_owner = -1;
            m_last  = NP - 1;
            m_skip  = 1'b0;
            m_hold  = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NP; k++) begin
                p = (m_last + k) % NP;
                if (pick < 0 && requests[p]) pick = p;
            end
            if (lx_request && (!m_skip || pick < 0)) begin
                m_owner = NP;
                m_skip  = 1'b1;
                m_hold  = 0;
            end else if (pick >= 0) begin
                m_owner = pick;
                m_last  = pick;
                m_skip  = 1'b0;
                m_hold  = 0;
            end
        end else begin
            if (m_hold < 255) m_hold++;
            if (m_hold == MH) m_to = 1'b1;
            if (!((m_owner == NP) ? lx_request : requests[m_owner])) m_owner = -1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] eg;
        logic [31:0] eid;
        eg  = (m_owner >= 0 && m_owner < NP) ? (32'd1 << m_owner) : 32'd0;
        eid = (m_owner >= 0 && m_owner < NP) ? 32'(m_owner) : 32'd0;
        chk({tag, ".grant"},    32'(grant),        eg);
        chk({tag, ".lx_grant"}, 32'(lx_grant),     32'(m_owner == NP));
        chk({tag, ".grant_id"}, 32'(grant_id),     eid);
        chk({tag, ".bus_busy"}, 32'(bus_busy),     32'(m_owner >= 0));
        chk({tag, ".timeout"},  32'(hold_timeout), 32'(m_to));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        requests   = '0;
        lx_request = 1'b0;
        reset      = 1'b0;
        step("rst");
        step("rst");
        reset = 1'b1;
    endtask

    initial begin
        // 1: reset with all ports requesting, then port 0 first
        requests = 4'b1111;
        for (int i = 0; i < 3; i++) step("t1_in_reset");
        reset = 1'b1;
        step("t1_first");
        chk("t1_grant0", 32'(grant), 32'd1);
        chk("t1_id0", 32'(grant_id), 32'd0);

        // 2: round-robin 0,1,2,3,0 with a single idle cycle between owners
        for (int g = 0; g < 5; g++) begin
            chk("t2_order", 32'(grant), 32'd1 << (g % NP));
            step("t2_hold");
            step("t2_hold");
            requests[g % NP] = 1'b0;
            step("t2_drop");
            chk("t2_gap", 32'({grant, lx_grant}), 32'd0);
            requests = 4'b1111;
            step("t2_next");
        end

        // 3: Lx priority, then forced yield to port 2, then back-to-back Lx when alone
        do_reset();
        requests   = 4'b0100;
        lx_request = 1'b1;
        step("t3_lx");
        chk("t3_lx_first", 32'(lx_grant), 32'd1);
        step("t3_hold");
        lx_request = 1'b0;
        step("t3_rel");
        lx_request = 1'b1;
        step("t3_yield");
        chk("t3_port2", 32'(grant), 32'b0100);
        chk("t3_no_lx", 32'(lx_grant), 32'd0);
        requests = 4'b0000;
        step("t3_rel2");
        step("t3_lx2");
        chk("t3_lx_again", 32'(lx_grant), 32'd1);
        lx_request = 1'b0;
        step("t3_rel3");
        lx_request = 1'b1;
        step("t3_lx3");
        chk("t3_lx_consec", 32'(lx_grant), 32'd1);
        lx_request = 1'b0;
        step("t3_rel4");
        step("t3_idle");

        // 4: sparse wrap from rr_ptr=3; late port 0 waits behind port 2
        do_reset();
        requests = 4'b0110;
        step("t4_p1");
        chk("t4_port1", 32'(grant), 32'b0010);
        step("t4_hold");
        requests = 4'b0111;
        step("t4_p0_req");
        requests = 4'b0101;
        step("t4_rel");
        step("t4_p2");
        chk("t4_port2", 32'(grant), 32'b0100);
        requests = 4'b0001;
        step("t4_rel2");
        step("t4_p0");
        chk("t4_port0", 32'(grant), 32'b0001);
        requests = 4'b0000;
        step("t4_rel3");
        step("t4_idle");

        // 5: watchdog on a 12-cycle hold, sticky until reset
        do_reset();
        requests = 4'b0010;
        step("t5_grant");
        for (int c = 1; c < 12; c++) begin
            step("t5_hold");
            chk("t5_timeout", 32'(hold_timeout), 32'(c >= MH));
            chk("t5_grant_kept", 32'(grant), 32'b0010);
        end
        requests = 4'b0000;
        step("t5_rel");
        chk("t5_sticky", 32'(hold_timeout), 32'd1);
        for (int i = 0; i < 3; i++) step("t5_idle");
        do_reset();
        step("t5_after_reset");
        chk("t5_cleared", 32'(hold_timeout), 32'd0);

        // 6: reset asserted between edges during an Lx grant
        do_reset();
        lx_request = 1'b1;
        step("t6_lx");
        chk("t6_lx_on", 32'(lx_grant), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_async_lx", 32'(lx_grant), 32'd0);
        chk("t6_async_busy", 32'(bus_busy), 32'd0);
        lx_request = 1'b0;
        requests   = 4'b1000;
        step("t6_in_reset");
        reset = 1'b1;
        step("t6_p3");
        chk("t6_port3", 32'(grant), 32'b1000);

        // Random traffic with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 5) == 0) requests[p] = ~requests[p];
            end
            if ($urandom_range(0, 7) == 0) lx_request = ~lx_request;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
